// File: rtl/breceive_pkg.sv
// Shared types and default sizing for the MCP receive stage.
package breceive_pkg;

    typedef enum logic {
        WAIT   = 1'b0,
        LOADED = 1'b1
    } state_t;

    localparam int WIDTH_DEF       = 8;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int CNT_W_DEF       = 8;

endpackage

// File: rtl/breceive_mcp_sync_ff.sv
// N-stage single-bit synchronizer with synchronous active-low reset.
module sync_ff #(
    parameter int N = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [N-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[N-2:0], d_i};
        end
    end

    assign q_o = sync_q[N-1];

endmodule

// File: rtl/breceive_mcp.sv
// b-domain receive side of the MCP crossing: captures the held a-domain word on each
// request toggle, hands it to the consumer, and returns a toggle acknowledge.
module breceive_mcp
    import breceive_pkg::*;
#(
    parameter int WIDTH       = WIDTH_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic             bclk,
    input  logic             brst_n,
    input  logic [WIDTH-1:0] adata,
    input  logic             aen,
    input  logic             bload,
    output logic [WIDTH-1:0] bdata,
    output logic             bvalid,
    output logic             back,
    output logic             berr,
    output logic [CNT_W-1:0] bcount
);

    logic             aen_sync;
    logic             hist_q;
    logic             b_en;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] bdata_q, bdata_d;
    logic             back_q, back_d;
    logic             berr_q, berr_d;
    logic [CNT_W-1:0] bcount_q, bcount_d;

    sync_ff #(.N(SYNC_STAGES)) u_aen_sync (
        .clk_i  (bclk),
        .rst_ni (brst_n),
        .d_i    (aen),
        .q_o    (aen_sync)
    );

    // One-cycle pulse per aen toggle, whichever direction it went.
    assign b_en = aen_sync ^ hist_q;

    always_ff @(posedge bclk) begin
        if (!brst_n) begin
            hist_q   <= 1'b0;
            state_q  <= WAIT;
            bdata_q  <= '0;
            back_q   <= 1'b0;
            berr_q   <= 1'b0;
            bcount_q <= '0;
        end else begin
            hist_q   <= aen_sync;
            state_q  <= state_d;
            bdata_q  <= bdata_d;
            back_q   <= back_d;
            berr_q   <= berr_d;
            bcount_q <= bcount_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        bdata_d  = bdata_q;
        back_d   = back_q;
        berr_d   = berr_q;
        bcount_d = bcount_q;
        case (state_q)
            WAIT: begin
                if (b_en) begin
                    bdata_d = adata;
                    state_d = LOADED;
                end
            end
            LOADED: begin
                // A request arriving before the previous word was accepted is dropped.
                if (b_en) begin
                    berr_d = 1'b1;
                end
                if (bload) begin
                    back_d   = ~back_q;
                    bcount_d = bcount_q + 1'b1;
                    state_d  = WAIT;
                end
            end
            default: state_d = WAIT;
        endcase
    end

    assign bdata  = bdata_q;
    assign bvalid = (state_q == LOADED);
    assign back   = back_q;
    assign berr   = berr_q;
    assign bcount = bcount_q;

endmodule

// File: tb/tb_breceive_mcp.sv
// Directed bench for breceive_mcp: vector table plus hand-written multi-cycle sequences.
module tb_breceive_mcp;

    logic       bclk;
    logic       brst_n;
    logic [7:0] adata;
    logic       aen;
    logic       bload;
    logic [7:0] bdata;
    logic       bvalid;
    logic       back;
    logic       berr;
    logic [7:0] bcount;

    int n_total;
    int n_pass;

    breceive_mcp #(.WIDTH(8), .SYNC_STAGES(2), .CNT_W(8)) dut (
        .bclk   (bclk),
        .brst_n (brst_n),
        .adata  (adata),
        .aen    (aen),
        .bload  (bload),
        .bdata  (bdata),
        .bvalid (bvalid),
        .back   (back),
        .berr   (berr),
        .bcount (bcount)
    );

    initial bclk = 1'b0;
    always #5 bclk = ~bclk;

    typedef struct {
        logic       aen;
        logic [7:0] adata;
        logic       bload;
        logic       bvalid;
        logic [7:0] bdata;
        logic       back;
        logic       berr;
        logic [7:0] bcount;
    } vec_t;

    vec_t vecs[22];

    task automatic step();
        @(posedge bclk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic v, input logic [7:0] d,
                           input logic bk, input logic e, input logic [7:0] c);
        chk({tag, ".bvalid"}, {31'd0, bvalid}, {31'd0, v});
        chk({tag, ".bdata"},  {24'd0, bdata},  {24'd0, d});
        chk({tag, ".back"},   {31'd0, back},   {31'd0, bk});
        chk({tag, ".berr"},   {31'd0, berr},   {31'd0, e});
        chk({tag, ".bcount"}, {24'd0, bcount}, {24'd0, c});
    endtask

    task automatic do_reset(input int edges);
        brst_n = 1'b0;
        for (int i = 0; i < edges; i++) begin
            adata = 8'($urandom);
            aen   = 1'($urandom);
            bload = 1'($urandom);
            step();
        end
        chk_all("reset", 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        brst_n = 1'b1;
        aen    = 1'b0;
        bload  = 1'b0;
        adata  = 8'h00;
    endtask

    // Toggle aen with new data, then run the three edges the word needs to land.
    task automatic send(input logic [7:0] d);
        adata = d;
        aen   = ~aen;
        step();
        step();
        step();
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        brst_n  = 1'b0;
        aen     = 1'b0;
        bload   = 1'b0;
        adata   = 8'h00;

        //            aen   adata  bload  bvalid bdata  back  berr  bcount
        vecs[0]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'd0};
        vecs[1]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'd0};
        vecs[2]  = '{1'b1, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 8'd0};
        vecs[3]  = '{1'b1, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 8'd0};
        vecs[4]  = '{1'b1, 8'hA5, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b0, 8'd1};
        vecs[5]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, 8'd1};
        vecs[6]  = '{1'b1, 8'hA5, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b0, 8'd1};
        vecs[7]  = '{1'b0, 8'h11, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, 8'd1};
        vecs[8]  = '{1'b0, 8'h11, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, 8'd1};
        vecs[9]  = '{1'b0, 8'h11, 1'b0, 1'b1, 8'h11, 1'b1, 1'b0, 8'd1};
        vecs[10] = '{1'b1, 8'h22, 1'b0, 1'b1, 8'h11, 1'b1, 1'b0, 8'd1};
        vecs[11] = '{1'b1, 8'h22, 1'b0, 1'b1, 8'h11, 1'b1, 1'b0, 8'd1};
        vecs[12] = '{1'b1, 8'h22, 1'b0, 1'b1, 8'h11, 1'b1, 1'b1, 8'd1};
        vecs[13] = '{1'b1, 8'h22, 1'b1, 1'b0, 8'h11, 1'b0, 1'b1, 8'd2};
        vecs[14] = '{1'b1, 8'h22, 1'b0, 1'b0, 8'h11, 1'b0, 1'b1, 8'd2};
        vecs[15] = '{1'b0, 8'h33, 1'b0, 1'b0, 8'h11, 1'b0, 1'b1, 8'd2};
        vecs[16] = '{1'b0, 8'h33, 1'b0, 1'b0, 8'h11, 1'b0, 1'b1, 8'd2};
        vecs[17] = '{1'b0, 8'h33, 1'b0, 1'b1, 8'h33, 1'b0, 1'b1, 8'd2};
        vecs[18] = '{1'b1, 8'h44, 1'b0, 1'b1, 8'h33, 1'b0, 1'b1, 8'd2};
        vecs[19] = '{1'b1, 8'h44, 1'b0, 1'b1, 8'h33, 1'b0, 1'b1, 8'd2};
        vecs[20] = '{1'b1, 8'h44, 1'b1, 1'b0, 8'h33, 1'b1, 1'b1, 8'd3};
        vecs[21] = '{1'b1, 8'h44, 1'b0, 1'b0, 8'h33, 1'b1, 1'b1, 8'd3};

        do_reset(2);

        for (int i = 0; i < 22; i++) begin
            aen   = vecs[i].aen;
            adata = vecs[i].adata;
            bload = vecs[i].bload;
            step();
            chk_all($sformatf("vec%0d", i), vecs[i].bvalid, vecs[i].bdata,
                    vecs[i].back, vecs[i].berr, vecs[i].bcount);
        end

        // Consumer stall: word sits for 20 cycles, then accepted in one edge.
        do_reset(2);
        send(8'h3C);
        for (int i = 0; i < 20; i++) begin
            step();
            chk($sformatf("stall%0d.bvalid", i), {31'd0, bvalid}, 32'd1);
            chk($sformatf("stall%0d.bdata", i),  {24'd0, bdata},  32'h3C);
            chk($sformatf("stall%0d.back", i),   {31'd0, back},   32'd0);
        end
        bload = 1'b1;
        step();
        bload = 1'b0;
        chk_all("stall_accept", 1'b0, 8'h3C, 1'b1, 1'b0, 8'd1);

        // Counter wrap over 256 back-to-back transfers.
        do_reset(2);
        for (int i = 0; i < 256; i++) begin
            send(8'(i));
            chk($sformatf("wrap%0d.bdata", i), {24'd0, bdata}, 32'(i & 8'hFF));
            bload = 1'b1;
            step();
            bload = 1'b0;
        end
        chk_all("wrap_end", 1'b0, 8'hFF, 1'b0, 1'b0, 8'd0);

        // Reset while holding a word, then a clean transfer afterwards.
        send(8'hFF);
        chk_all("pre_midreset", 1'b1, 8'hFF, 1'b0, 1'b0, 8'd0);
        do_reset(1);
        send(8'h5A);
        chk_all("post_reset_load", 1'b1, 8'h5A, 1'b0, 1'b0, 8'd0);
        bload = 1'b1;
        step();
        bload = 1'b0;
        chk_all("post_reset_accept", 1'b0, 8'h5A, 1'b1, 1'b0, 8'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
